// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - two-port round-robin arbiter in front of a single-port RAM
// Tracks in-flight reads through the RAM latency and returns each word to its issuing port.
module ram_port_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q
);

    logic              last_q;
    logic              last_d;
    logic              accept;
    logic              rd_push;
    logic [RD_LAT-1:0] tag_vld_q;
    logic [RD_LAT-1:0] tag_port_q;
    logic              cap_vld_q;
    logic              cap_port_q;
    logic [DATA_W-1:0] cap_data_q;
    logic              m0_rvalid_q;
    logic              m1_rvalid_q;
    logic [DATA_W-1:0] m0_rdata_q;
    logic [DATA_W-1:0] m1_rdata_q;

    // last_q names the most recently granted port; on a tie the other one wins.
    always_comb begin
        m0_gnt      = 1'b0;
        m1_gnt      = 1'b0;
        ram_address = '0;
        ram_data    = '0;
        ram_wren    = 1'b0;
        if (!reset) begin
            if (m0_req && m1_req) begin
                m0_gnt = last_q;
                m1_gnt = !last_q;
            end else begin
                m0_gnt = m0_req;
                m1_gnt = m1_req;
            end
        end
        if (m0_gnt) begin
            ram_address = m0_addr;
            ram_data    = m0_wdata;
            ram_wren    = m0_we;
        end else if (m1_gnt) begin
            ram_address = m1_addr;
            ram_data    = m1_wdata;
            ram_wren    = m1_we;
        end
        accept  = m0_gnt | m1_gnt;
        rd_push = accept && !ram_wren;
        last_d  = accept ? m1_gnt : last_q;
    end

    // ram_q is only stable for one edge, so it is captured as the tag exits and
    // presented on the port outputs one edge later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q      <= 1'b1;
            tag_vld_q   <= '0;
            tag_port_q  <= '0;
            cap_vld_q   <= 1'b0;
            cap_port_q  <= 1'b0;
            cap_data_q  <= '0;
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
        end else begin
            last_q        <= last_d;
            tag_vld_q[0]  <= rd_push;
            tag_port_q[0] <= m1_gnt;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_vld_q[i]  <= tag_vld_q[i-1];
                tag_port_q[i] <= tag_port_q[i-1];
            end
            cap_vld_q  <= tag_vld_q[RD_LAT-1];
            cap_port_q <= tag_port_q[RD_LAT-1];
            if (tag_vld_q[RD_LAT-1]) begin
                cap_data_q <= ram_q;
            end
            m0_rvalid_q <= cap_vld_q && !cap_port_q;
            m1_rvalid_q <= cap_vld_q && cap_port_q;
            if (cap_vld_q && !cap_port_q) begin
                m0_rdata_q <= cap_data_q;
            end
            if (cap_vld_q && cap_port_q) begin
                m1_rdata_q <= cap_data_q;
            end
        end
    end

    assign m0_rvalid = m0_rvalid_q;
    assign m1_rvalid = m1_rvalid_q;
    assign m0_rdata  = m0_rdata_q;
    assign m1_rdata  = m1_rdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - self-checking bench for ram_port_arbiter
// Reference model: shadow memory plus a queue of reads due at known sample points.
module tb_ram_port_arbiter;

    logic        clk;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [15:0] m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [15:0] ram_address;
    logic [31:0] ram_data;
    logic        ram_wren;
    logic [31:0] ram_q;

    ram_port_arbiter dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
        .ram_q(ram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM with registered address, one-edge read latency.
    logic [31:0] ram_mem [0:255];
    logic [15:0] ram_addr_r;
    always @(posedge clk) begin
        if (ram_wren) ram_mem[ram_address[7:0]] <= ram_data;
        ram_addr_r <= ram_address;
    end
    assign ram_q = ram_mem[ram_addr_r[7:0]];

    typedef struct { int due; bit port; logic [31:0] data; } rd_t;
    rd_t         pend[$];
    logic [31:0] shadow [0:255];
    bit          model_last;
    logic [31:0] exp_rd0, exp_rd1;
    int          neg_idx;
    int          n_checks, n_fail;
    int          wren_cnt, rv0_cnt, rv0_first, rv0_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (sample %0d)", name, act, exp, neg_idx);
        end
    endtask

    // Compare point between edges; also advances the model for the coming edge.
    task automatic at_neg();
        bit          g0, g1, ev0, ev1;
        logic        we;
        logic [15:0] a;
        logic [31:0] wd;
        rd_t         r;
        @(negedge clk);
        neg_idx++;
        g0 = 1'b0;
        g1 = 1'b0;
        if (!reset) begin
            if (m0_req && m1_req) begin
                g0 = model_last;
                g1 = !model_last;
            end else begin
                g0 = m0_req;
                g1 = m1_req;
            end
        end
        we = 1'b0; a = '0; wd = '0;
        if (g0) begin we = m0_we; a = m0_addr; wd = m0_wdata; end
        if (g1) begin we = m1_we; a = m1_addr; wd = m1_wdata; end
        check("m0_gnt", m0_gnt, g0);
        check("m1_gnt", m1_gnt, g1);
        check("ram_wren", ram_wren, we);
        check("ram_address", ram_address, a);
        check("ram_data", ram_data, wd);
        if (ram_wren) wren_cnt++;

        ev0 = 1'b0;
        ev1 = 1'b0;
        if (reset) begin
            pend.delete();
            exp_rd0 = '0;
            exp_rd1 = '0;
        end else begin
            while (pend.size() > 0 && pend[0].due == neg_idx) begin
                r = pend.pop_front();
                if (r.port) begin ev1 = 1'b1; exp_rd1 = r.data; end
                else begin ev0 = 1'b1; exp_rd0 = r.data; end
            end
        end
        check("m0_rvalid", m0_rvalid, ev0);
        check("m1_rvalid", m1_rvalid, ev1);
        check("m0_rdata", m0_rdata, exp_rd0);
        check("m1_rdata", m1_rdata, exp_rd1);
        if (m0_rvalid) begin
            if (rv0_cnt == 0) rv0_first = neg_idx;
            rv0_last = neg_idx;
            rv0_cnt++;
        end

        if (g0 || g1) begin
            if (we) shadow[a[7:0]] = wd;
            else pend.push_back('{due: neg_idx + 3, port: g1, data: shadow[a[7:0]]});
            model_last = g1;
        end
        if (reset) model_last = 1'b1;
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        at_neg();
        to_pos();
    endtask

    task automatic idle_ports();
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] gseq [0:3];
        int         wait_c, n0, n1, same, got;
        bit         prev_g1;
        n_checks = 0; n_fail = 0; neg_idx = 0; model_last = 1'b1;
        exp_rd0 = '0; exp_rd1 = '0; wren_cnt = 0; rv0_cnt = 0; rv0_first = 0; rv0_last = 0;
        reset = 1'b1;
        idle_ports();
        step();
        m0_req = 1; m1_req = 1;
        at_neg();
        check("reset_gnt", {m1_gnt, m0_gnt}, 2'b00);
        check("reset_rdata", m0_rdata, 32'h0);
        to_pos();
        idle_ports();
        reset = 1'b0;

        // Preload addresses 0..104 through m0, then overwrite 5.
        for (int a = 0; a < 105; a++) begin
            m0_req = 1; m0_we = 1; m0_addr = 16'(a); m0_wdata = 32'hC0DE0000 | 32'(a);
            step();
        end
        m0_addr = 16'd5; m0_wdata = 32'hDEADBEEF;
        step();
        idle_ports();
        step();

        // Single read.
        m0_req = 1; m0_addr = 16'd5;
        at_neg();
        check("single_gnt", m0_gnt, 1'b1);
        to_pos();
        idle_ports();
        step();
        step();
        at_neg();
        check("single_rvalid", m0_rvalid, 1'b1);
        check("single_rdata", m0_rdata, 32'hDEADBEEF);
        check("single_m1_rvalid", m1_rvalid, 1'b0);
        to_pos();

        // Tie after reset: m0 first, then alternate.
        reset = 1'b1;
        step();
        reset = 1'b0;
        m0_req = 1; m0_addr = 16'd1; m1_req = 1; m1_addr = 16'd2;
        for (int i = 0; i < 4; i++) begin
            at_neg();
            gseq[i] = {m1_gnt, m0_gnt};
            to_pos();
        end
        idle_ports();
        check("tie_g0", gseq[0], 2'b01);
        check("tie_g1", gseq[1], 2'b10);
        check("tie_g2", gseq[2], 2'b01);
        check("tie_g3", gseq[3], 2'b10);
        for (int i = 0; i < 4; i++) step();
        check("tie_m0_word", m0_rdata, 32'hC0DE0001);
        check("tie_m1_word", m1_rdata, 32'hC0DE0002);

        // Write then read on m1.
        wren_cnt = 0;
        m1_req = 1; m1_we = 1; m1_addr = 16'd104; m1_wdata = 32'h12345678;
        step();
        m1_we = 0;
        step();
        idle_ports();
        step();
        step();
        at_neg();
        check("wr_rd_rvalid", m1_rvalid, 1'b1);
        check("wr_rd_rdata", m1_rdata, 32'h12345678);
        to_pos();
        check("wr_rd_wren_count", wren_cnt, 1);

        // Streaming reads 0..104 on m0.
        got = 0; rv0_cnt = 0;
        m0_req = 1;
        for (int a = 0; a < 105; a++) begin
            m0_addr = 16'(a);
            at_neg();
            if (m0_gnt) got++;
            to_pos();
        end
        idle_ports();
        for (int i = 0; i < 4; i++) step();
        check("stream_grants", got, 105);
        check("stream_rvalid_count", rv0_cnt, 105);
        check("stream_rvalid_span", rv0_last - rv0_first, 104);
        check("stream_last_word", m0_rdata, 32'h12345678);

        // Contention: m1 streams, m0 joins at cycle 10.
        wait_c = 99; n0 = 0; n1 = 0; same = 0; prev_g1 = 1'b0;
        m1_req = 1; m1_addr = 16'd20;
        for (int c = 0; c < 24; c++) begin
            if (c == 10) begin m0_req = 1; m0_addr = 16'd50; end
            at_neg();
            if (wait_c != 99 && c <= wait_c + 18) begin
                if (m0_gnt) n0++;
                if (m1_gnt) n1++;
                if (m1_gnt == prev_g1) same++;
            end
            if (c >= 10 && wait_c == 99 && m0_gnt) wait_c = c - 10;
            prev_g1 = m1_gnt;
            to_pos();
            if (m1_gnt) m1_addr = m1_addr + 16'd1;
        end
        idle_ports();
        for (int i = 0; i < 4; i++) step();
        check("contend_wait_le1", 32'(wait_c <= 1), 32'd1);
        check("contend_n0", n0, n1);
        check("contend_no_repeat", same, 0);

        // Reset one cycle after a read is accepted.
        m0_req = 1; m0_addr = 16'd7;
        step();
        idle_ports();
        step();
        reset = 1'b1;
        m0_req = 1; m0_addr = 16'd1; m1_req = 1; m1_addr = 16'd2;
        #1;
        check("rst_m0_rdata", m0_rdata, 32'h0);
        check("rst_m1_rdata", m1_rdata, 32'h0);
        check("rst_m0_gnt", m0_gnt, 1'b0);
        check("rst_wren", ram_wren, 1'b0);
        step();
        step();
        reset = 1'b0;
        at_neg();
        check("post_rst_tie", {m1_gnt, m0_gnt}, 2'b01);
        to_pos();
        idle_ports();
        for (int i = 0; i < 6; i++) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-port round-robin arbiter that shares the single-port `RAMMemory` instance (16-bit word address, 32-bit data, one write enable, registered address) between two requesters, such as the pipeline's MEM stage and a debug/DMA dump engine. It issues at most one RAM access per cycle. It tracks in-flight reads through the RAM's read latency and returns each read word, registered, to the port that issued it.

## Interface
- `ADDR_W`, 16: RAM word address width.
- `DATA_W`, 32: RAM data width.
- `RD_LAT`, 1: RAM read latency in clock edges, legal range 1..3. An address sampled at edge N gives `ram_q` valid before edge N+RD_LAT.

- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `m0_req` / `m1_req` in 1: access request, held until granted.
- `m0_we` / `m1_we` in 1: 1 = write, 0 = read; held with req.
- `m0_addr` / `m1_addr` in ADDR_W: word address; held with req.
- `m0_wdata` / `m1_wdata` in DATA_W: write data; held with req.
- `m0_gnt` / `m1_gnt` out 1: combinational grant. Access is accepted at an edge where req && gnt.
- `m0_rvalid` / `m1_rvalid` out 1: registered one-cycle read-return strobe.
- `m0_rdata` / `m1_rdata` out DATA_W: registered read data, valid while rvalid.
- `ram_address` out ADDR_W: to `RAMMemory.address`.
- `ram_data` out DATA_W: to `RAMMemory.data`.
- `ram_wren` out 1: to `RAMMemory.wren`.
- `ram_q` in DATA_W: from `RAMMemory.q`.

## Operation
- **Round-robin pointer:** `last` is a 1-bit register. It holds the port granted most recently and resets to 1, so m0 wins the first tie.
- **Grant logic (combinational):**
  - Only m0 requesting: grant m0.
  - Only m1 requesting: grant m1.
  - Both requesting: grant the port != `last`.
  - Neither requesting: no grant.
  - While `reset` is high, both gnt outputs are 0.
- **Pointer update:** `last` updates only at an edge with an accepted access.
- **RAM drive:**
  - When a port is granted, `ram_address`, `ram_data` and `ram_wren` are driven combinationally from that port's addr, wdata and we.
  - When nothing is granted, `ram_address` = 0, `ram_data` = 0 and `ram_wren` = 0.
  - `ram_wren` is never 1 during reset.
- **Read tracking:** each accepted read pushes a {valid, port} tag into an RD_LAT-deep shift register. Writes and idle cycles push an invalid tag.
  - When a valid tag exits the shift register, `ram_q` is captured into the tagged port's `rdata`, and that port's `rvalid` = 1 for exactly one cycle.
  - The other port's `rvalid` = 0 that cycle, and its `rdata` holds its previous value.
- **Ordering:** accesses reach the RAM strictly in grant order. A read accepted at any edge after a write to the same address returns the written data. Same-edge conflicts cannot occur.
- **Throughput:** one access per cycle.
  - A single port requesting every cycle is granted every cycle.
  - Two ports both requesting continuously each receive exactly every other grant.
- **Starvation:** none. A waiting requester is granted within 2 edges of asserting req.
- **Reset (asynchronous, mid-operation allowed):**
  - Clears the tag pipeline and sets `last` = 1.
  - Forces `m*_rvalid` = 0 and `m*_rdata` = 0.
  - In-flight reads are discarded and never returned.
  - A write accepted before reset assertion stays committed in the RAM.

## Timing
- Grant is combinational in the cycle that req is high; acceptance happens at the next rising edge N.
- Read accepted at edge N: `rvalid` and `rdata` are high/valid between edge N+RD_LAT+1 and edge N+RD_LAT+2. With RD_LAT=1, data appears 2 edges after acceptance.
- Write accepted at edge N: committed in the RAM at edge N. No response strobe.
- Back-to-back reads produce back-to-back `rvalid` pulses with the same latency.
- Outputs after reset release: gnt follows req immediately; `rvalid` = 0 until a read completes.

## Test plan
- **Single read:** preload addr 5 = 0xDEADBEEF. m0 reads 5, accepted at edge N → `m0_rvalid` = 1, `m0_rdata` = 0xDEADBEEF in the cycle after edge N+2. `m1_rvalid` stays 0.
- **Tie arbitration:** m0 and m1 both request reads (addrs 1 and 2) after reset.
  - Grant sequence is m0, m1, m0, m1.
  - Returns alternate ports with the correct words.
- **Write then read:** m1 writes 0x12345678 to addr 104, then reads 104 on the next cycle → `m1_rdata` = 0x12345678. `ram_wren` is high for exactly one cycle.
- **Streaming reads:** m0 reads addrs 0..104 continuously, m1 idle.
  - 105 consecutive grants, then 105 consecutive `rvalid` pulses.
  - Data is in address order.
- **Contention mid-stream:** m1 streams reads; m0 asserts req at cycle 10 → m0 is granted within 2 edges, then the two ports interleave 1:1.
- **Reset mid-read:** assert `reset` one cycle after a read is accepted.
  - No `rvalid` for that read.
  - Outputs are 0 immediately.
  - After release, the first tie goes to m0.
